// File: rtl/pmm_match_stats.sv
// Match-statistics block: per-channel saturating event counters, last non-zero IDs
// and an event log FIFO, all reached through the udp_reg request/ack interface.
module pmm_match_stats #(
  parameter int NUM_CH    = 4,
  parameter int ID_W      = 14,
  parameter int CNT_W     = 32,
  parameter int LOG_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH*ID_W-1:0] ev_id,
  input  logic                   udp_reg_req,
  input  logic                   udp_reg_rd_wr_L,
  input  logic [19:0]            udp_reg_addr,
  input  logic [31:0]            udp_reg_wr_data,
  output logic                   udp_reg_ack,
  output logic [31:0]            udp_reg_rd_data
);

  localparam int AW = $clog2(LOG_DEPTH);
  localparam int LW = 3 + ID_W;
  localparam logic [AW:0]      OCC_FULL = (AW+1)'(LOG_DEPTH);
  localparam logic [AW:0]      OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_CH-1:0] en_q;
  logic              frz_q;
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [ID_W-1:0]   last_q [NUM_CH];
  logic [LW-1:0]     log_q  [LOG_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       occ_q, occ_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              ovf_q, ovf_d;
  logic              ack_q;
  logic [31:0]       rd_data_q, rd_data_d;

  logic [7:0]        addr8;
  logic              wr_en, rd_en, ctrl_wr, clr_wr, flush, pop;
  logic [NUM_CH-1:0] clr_ch, acc;
  logic [3:0]        n_acc, n_drop;
  logic              push_req, push_ok, discard, full;
  logic [2:0]        push_ch;
  logic [ID_W-1:0]   push_id;
  logic [CNT_W:0]    drop_sum;
  logic [LW-1:0]     head;
  logic [31:0]       rd_word;
  logic              unused_in;

  assign unused_in = ^{udp_reg_addr[19:8], udp_reg_wr_data};

  function automatic logic [31:0] zext_cnt(input logic [CNT_W-1:0] v);
    logic [31:0] r;
    r = '0;
    r[CNT_W-1:0] = v;
    return r;
  endfunction

  function automatic logic [15:0] zext_id(input logic [ID_W-1:0] v);
    logic [15:0] r;
    r = '0;
    r[ID_W-1:0] = v;
    return r;
  endfunction

  assign addr8   = udp_reg_addr[7:0];
  assign wr_en   = udp_reg_req & ~udp_reg_rd_wr_L;
  assign rd_en   = udp_reg_req & udp_reg_rd_wr_L;
  assign ctrl_wr = wr_en && (addr8 == 8'h01);
  assign clr_wr  = wr_en && (addr8 == 8'h02);
  assign clr_ch  = clr_wr ? udp_reg_wr_data[NUM_CH-1:0] : '0;
  assign flush   = clr_wr & udp_reg_wr_data[31];
  assign full    = (occ_q == OCC_FULL);
  assign pop     = rd_en && (addr8 == 8'h04) && (occ_q != '0);

  // Lowest-index accepted event goes to the log; the rest are counted as drops.
  always_comb begin
    acc      = '0;
    n_acc    = 4'd0;
    push_req = 1'b0;
    push_ch  = 3'd0;
    push_id  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      acc[i] = (ev_id[i*ID_W +: ID_W] != '0) && en_q[i] && !frz_q;
      if (acc[i]) begin
        n_acc = n_acc + 4'd1;
        if (!push_req) begin
          push_req = 1'b1;
          push_ch  = 3'(i);
          push_id  = ev_id[i*ID_W +: ID_W];
        end
      end
    end
  end

  assign push_ok = push_req && (!full || pop);
  assign discard = push_req && full && !pop;

  always_comb begin
    n_drop = 4'd0;
    if (push_req) n_drop = n_acc - 4'd1;
    if (discard)  n_drop = n_drop + 4'd1;
    drop_sum = {1'b0, drop_q} + (CNT_W+1)'(n_drop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    ovf_d    = ovf_q | discard;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      drop_d   = '0;
      ovf_d    = 1'b0;
    end else begin
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (push_ok && !pop)      occ_d = occ_q + OCC_ONE;
      else if (!push_ok && pop) occ_d = occ_q - OCC_ONE;
    end
  end

  always_comb begin
    head    = log_q[rd_ptr_q];
    rd_word = 32'hDEAD_DEAD;
    case (addr8)
      8'h00: rd_word = {16'hAAAA, 8'(NUM_CH), 8'(LOG_DEPTH)};
      8'h01: begin
        rd_word = '0;
        rd_word[31] = frz_q;
        rd_word[NUM_CH-1:0] = en_q;
      end
      8'h02: rd_word = '0;
      8'h03: begin
        rd_word = '0;
        rd_word[31] = ovf_q;
        rd_word[AW:0] = occ_q;
      end
      8'h04: rd_word = (occ_q != '0) ?
                       {1'b1, 4'b0, head[ID_W +: 3], 8'b0, zext_id(head[ID_W-1:0])} : '0;
      8'h05: rd_word = zext_cnt(drop_q);
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (addr8 == 8'(16 + 2*i)) rd_word = zext_cnt(cnt_q[i]);
          if (addr8 == 8'(17 + 2*i)) rd_word = {16'h0, zext_id(last_q[i])};
        end
      end
    endcase
    rd_data_d = rd_en ? rd_word : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q      <= '1;
      frz_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      drop_q    <= '0;
      ovf_q     <= 1'b0;
      ack_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (ctrl_wr) begin
        en_q  <= udp_reg_wr_data[NUM_CH-1:0];
        frz_q <= udp_reg_wr_data[31];
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      drop_q    <= drop_d;
      ovf_q     <= ovf_d;
      ack_q     <= udp_reg_req;
      rd_data_q <= rd_data_d;
    end
  end

  // Clear takes priority over a same-cycle event on that channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        last_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr_ch[i]) begin
          cnt_q[i]  <= '0;
          last_q[i] <= '0;
        end else if (acc[i]) begin
          if (cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + CNT_ONE;
          last_q[i] <= ev_id[i*ID_W +: ID_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) log_q[wr_ptr_q] <= {push_ch, push_id};
  end

  assign udp_reg_ack     = ack_q;
  assign udp_reg_rd_data = rd_data_q;

endmodule

// File: tb/tb_pmm_match_stats.sv
// Bench for pmm_match_stats: table of register/event steps plus hand sequences,
// with read expectations queued at request time and checked when the ack arrives.
module tb_pmm_match_stats;

  localparam int EVW = 4 * 14;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [EVW-1:0] ev_id = '0;
  logic           udp_reg_req = 1'b0;
  logic           udp_reg_rd_wr_L = 1'b0;
  logic [19:0]    udp_reg_addr = '0;
  logic [31:0]    udp_reg_wr_data = '0;
  logic           udp_reg_ack;
  logic [31:0]    udp_reg_rd_data;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] exp;
    string       nm;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic           r;
    logic           rd;
    logic [7:0]     a;
    logic [31:0]    wd;
    logic [EVW-1:0] ev;
    logic [31:0]    exp;
    string          nm;
  } vec_t;
  vec_t tbl[$];

  pmm_match_stats #(
    .NUM_CH(4), .ID_W(14), .CNT_W(8), .LOG_DEPTH(16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ev_id           (ev_id),
    .udp_reg_req     (udp_reg_req),
    .udp_reg_rd_wr_L (udp_reg_rd_wr_L),
    .udp_reg_addr    (udp_reg_addr),
    .udp_reg_wr_data (udp_reg_wr_data),
    .udp_reg_ack     (udp_reg_ack),
    .udp_reg_rd_data (udp_reg_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [EVW-1:0] chv(input int ch, input int id);
    logic [EVW-1:0] v;
    v = '0;
    v[ch*14 +: 14] = 14'(id);
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock cycle of stimulus; inputs are held until the next step.
  task automatic step(input logic r, input logic rd, input logic [7:0] a, input logic [31:0] wd,
                      input logic [EVW-1:0] ev, input logic [31:0] exp, input string nm);
    sb_t e;
    @(negedge clk);
    udp_reg_req     = r;
    udp_reg_rd_wr_L = rd;
    udp_reg_addr    = {12'h0, a};
    udp_reg_wr_data = wd;
    ev_id           = ev;
    if (r) begin
      e.exp = rd ? exp : 32'h0;
      e.nm  = nm;
      sb_q.push_back(e);
    end
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
    step(1'b1, 1'b1, a, 32'h0, '0, exp, nm);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] wd, input string nm);
    step(1'b1, 1'b0, a, wd, '0, 32'h0, nm);
  endtask

  task automatic idle(input logic [EVW-1:0] ev);
    step(1'b0, 1'b0, 8'h0, 32'h0, ev, 32'h0, "");
  endtask

  task automatic add(input logic r, input logic rdf, input logic [7:0] a, input logic [31:0] wd,
                     input logic [EVW-1:0] ev, input logic [31:0] exp, input string nm);
    vec_t v;
    v.r = r; v.rd = rdf; v.a = a; v.wd = wd; v.ev = ev; v.exp = exp; v.nm = nm;
    tbl.push_back(v);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (udp_reg_ack) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ack: data %h with nothing pending", udp_reg_rd_data);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check(e.nm, udp_reg_rd_data, e.exp);
        end
      end else if (udp_reg_rd_data !== 32'h0) begin
        check("rd_data_idle", udp_reg_rd_data, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Main vector table: {req, read, addr, wdata, events, expected read data, name}
    add(1, 1, 8'h00, 0, '0, 32'hAAAA0410, "id_rst");
    add(1, 1, 8'h01, 0, '0, 32'h0000000F, "ctrl_rst");
    add(1, 1, 8'h10, 0, '0, 32'h0, "cnt0_rst");
    add(1, 1, 8'h03, 0, '0, 32'h0, "status_rst");
    add(1, 1, 8'h05, 0, '0, 32'h0, "drop_rst");
    add(1, 1, 8'h7F, 0, '0, 32'hDEADDEAD, "unmapped_7f");
    add(1, 1, 8'h02, 0, '0, 32'h0, "clear_reads0");
    add(1, 1, 8'h18, 0, '0, 32'hDEADDEAD, "cnt4_unmapped");
    add(0, 0, 8'h00, 0, chv(1, 5), 0, "");
    add(0, 0, 8'h00, 0, chv(1, 0), 0, "");
    add(0, 0, 8'h00, 0, chv(1, 9), 0, "");
    add(1, 1, 8'h12, 0, '0, 32'd2, "cnt1");
    add(1, 1, 8'h13, 0, '0, 32'd9, "last1");
    add(1, 1, 8'h04, 0, '0, 32'h81000005, "pop_first");
    add(1, 1, 8'h04, 0, '0, 32'h81000009, "pop_second");
    add(1, 1, 8'h04, 0, '0, 32'h0, "pop_empty");
    add(1, 1, 8'h03, 0, '0, 32'h0, "status_empty");
    add(0, 0, 8'h00, 0, chv(0, 3) | chv(2, 7), 0, "");
    add(1, 1, 8'h10, 0, '0, 32'd1, "sim_cnt0");
    add(1, 1, 8'h14, 0, '0, 32'd1, "sim_cnt2");
    add(1, 1, 8'h03, 0, '0, 32'd1, "sim_occ");
    add(1, 1, 8'h05, 0, '0, 32'd1, "sim_drop");
    add(1, 1, 8'h04, 0, '0, 32'h80000003, "sim_pop");
    add(1, 1, 8'h04, 0, '0, 32'h0, "sim_pop2");
    add(1, 1, 8'h15, 0, '0, 32'd7, "sim_last2");
    add(1, 0, 8'h00, 32'hFFFFFFFF, '0, 0, "wr_ro_ack");
    add(1, 1, 8'h00, 0, '0, 32'hAAAA0410, "id_after_wr");
    add(1, 1, 8'h16, 0, chv(3, 4), 32'h0, "cnt3_same_edge");
    add(1, 1, 8'h16, 0, '0, 32'd1, "cnt3_next");
    add(1, 1, 8'h04, 0, '0, 32'h83000004, "pop_ch3");
    add(1, 1, 8'h04, 0, chv(1, 'h22), 32'h0, "pop_push_empty");
    add(1, 1, 8'h04, 0, '0, 32'h81000022, "pop_pushed");
    add(1, 0, 8'h02, 32'h80000000, '0, 0, "flush_ack");
    add(1, 1, 8'h05, 0, '0, 32'h0, "drop_flushed");
    add(1, 0, 8'h02, 32'h00000001, chv(0, 6), 0, "clr_ev_ack");
    add(1, 1, 8'h10, 0, '0, 32'h0, "clr_wins_cnt");
    add(1, 1, 8'h11, 0, '0, 32'h0, "clr_wins_last");
    add(1, 0, 8'h02, 32'h80000000, chv(1, 1), 0, "flush_push_ack");
    add(1, 1, 8'h03, 0, '0, 32'h0, "flush_wins");
    add(1, 1, 8'h12, 0, '0, 32'd4, "cnt1_total");
    add(1, 0, 8'h01, 32'h8000000F, '0, 0, "freeze_ack");
    add(0, 0, 8'h00, 0, chv(0, 2) | chv(2, 3), 0, "");
    add(1, 1, 8'h10, 0, '0, 32'h0, "frz_cnt0");
    add(1, 1, 8'h14, 0, '0, 32'd1, "frz_cnt2");
    add(1, 1, 8'h03, 0, '0, 32'h0, "frz_log");
    add(1, 1, 8'h01, 0, '0, 32'h8000000F, "frz_ctrl");
    add(1, 0, 8'h02, 32'h00000004, '0, 0, "frz_clr_ack");
    add(1, 1, 8'h14, 0, '0, 32'h0, "frz_clr_cnt2");
    add(1, 1, 8'h15, 0, '0, 32'h0, "frz_clr_last2");
    add(1, 0, 8'h01, 32'h0000000E, '0, 0, "dis_ack");
    add(0, 0, 8'h00, 0, chv(0, 5), 0, "");
    add(1, 1, 8'h10, 0, '0, 32'h0, "dis_cnt0");
    add(1, 1, 8'h01, 0, '0, 32'h0000000E, "dis_ctrl");
    add(1, 1, 8'h03, 0, '0, 32'h0, "dis_log");
    add(1, 0, 8'h01, 32'h0000000F, chv(0, 1), 0, "en_same_edge_ack");
    add(0, 0, 8'h00, 0, chv(0, 1), 0, "");
    add(1, 1, 8'h10, 0, '0, 32'd1, "en_next_cnt0");
    add(1, 1, 8'h03, 0, '0, 32'd1, "en_next_log");
    add(1, 0, 8'h02, 32'h80000001, '0, 0, "clean_ack");
    add(1, 1, 8'h10, 0, '0, 32'h0, "clean_cnt0");
    add(1, 1, 8'h03, 0, '0, 32'h0, "clean_log");

    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < tbl.size(); k++)
      step(tbl[k].r, tbl[k].rd, tbl[k].a, tbl[k].wd, tbl[k].ev, tbl[k].exp, tbl[k].nm);

    // Counter and drop saturation with an 8-bit counter width.
    for (int k = 0; k < 300; k++) idle(chv(0, 'h3FFF));
    rd(8'h10, 32'h000000FF, "sat_cnt0");
    rd(8'h11, 32'h00003FFF, "sat_last0");
    rd(8'h05, 32'h000000FF, "sat_drop");
    rd(8'h03, 32'h80000010, "sat_status");
    wr(8'h02, 32'h80000001, "sat_clean_ack");
    rd(8'h03, 32'h0, "sat_clean_log");
    rd(8'h05, 32'h0, "sat_clean_drop");

    // Overflow, pop+push on a full log, and pointer wrap.
    for (int k = 1; k <= 17; k++) idle(chv(2, k));
    rd(8'h03, 32'h80000010, "ovf_status");
    rd(8'h05, 32'd1, "ovf_drop");
    step(1'b1, 1'b1, 8'h04, 32'h0, chv(2, 'h30), 32'h82000001, "full_pop_push");
    rd(8'h03, 32'h80000010, "full_occ_kept");
    rd(8'h05, 32'd1, "full_no_drop");
    for (int k = 2; k <= 16; k++) rd(8'h04, 32'h82000000 | 32'(k), "drain_pop");
    rd(8'h04, 32'h82000030, "drain_last");
    rd(8'h04, 32'h0, "drain_empty");
    rd(8'h03, 32'h80000000, "ovf_sticky");

    // Reset in the middle of a read request.
    idle(chv(1, 7));
    wr(8'h01, 32'h80000003, "pre_rst_ctrl_ack");
    @(negedge clk);
    udp_reg_req = 1'b1; udp_reg_rd_wr_L = 1'b1; udp_reg_addr = 20'h1; ev_id = '0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("abort_ack", {31'h0, udp_reg_ack}, 32'h0);
    check("abort_data", udp_reg_rd_data, 32'h0);
    @(negedge clk);
    udp_reg_req = 1'b0;
    check("abort_ack_late", {31'h0, udp_reg_ack}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    rd(8'h01, 32'h0000000F, "post_rst_ctrl");
    rd(8'h12, 32'h0, "post_rst_cnt1");
    rd(8'h13, 32'h0, "post_rst_last1");
    rd(8'h03, 32'h0, "post_rst_status");
    rd(8'h05, 32'h0, "post_rst_drop");
    rd(8'h04, 32'h0, "post_rst_pop");
    rd(8'h7F, 32'hDEADDEAD, "post_rst_unmapped");

    repeat (4) idle('0);
    check("pending_acks", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pmm_match_stats.md
# pmm_match_stats

Parametrised match-statistics and event-log block for the payload engine. It sits beside the pattern-matching top and takes N channels of match-ID streams: rule IDs, static pattern IDs, nocase pattern IDs, PCRE IDs and so on. For each channel it keeps a saturating event counter and the last non-zero ID, and it records per-event entries in a FIFO log. All of this is exposed, with enable, clear and freeze control, through the CPCI `udp_reg_*` interface.

## Interface
Parameters:
- `NUM_CH`, 4 — number of ID channels, 1..8.
- `ID_W`, 14 — width of each channel ID, 1..16.
- `CNT_W`, 32 — width of the event and drop counters, 8..32; zero-extended to 32 bits on read.
- `LOG_DEPTH`, 16 — number of event-log entries; must be a power of 2, 2..256.

Ports:
- `clk` input 1 — the single clock.
- `rst` input 1 — reset, asynchronous and active-low.
- `ev_id` input `NUM_CH*ID_W` — channel i occupies bits [i*ID_W +: ID_W]. A non-zero value is one event in that cycle; zero means no event.
- `udp_reg_req` input 1 — single-cycle register request pulse.
- `udp_reg_rd_wr_L` input 1 — 1 = read, 0 = write.
- `udp_reg_addr` input 20 — word address; only [7:0] is decoded.
- `udp_reg_wr_data` input 32 — write data.
- `udp_reg_ack` output reg 1 — request acknowledge.
- `udp_reg_rd_data` output reg 32 — read data, valid while `udp_reg_ack` = 1.

## Operation
Register map, by `addr[7:0]`:
- 0x00 ID (RO): {16'hAAAA, NUM_CH[7:0], LOG_DEPTH[7:0]}.
- 0x01 CTRL (RW):
  - bits [NUM_CH-1:0] are channel enables; reset value is all ones.
  - bit 31 is freeze; reset value 0.
  - Other bits are read as 0.
- 0x02 CLEAR (WO, reads 0):
  - Writing 1 to bit i zeroes channel i's counter and last-ID.
  - Writing 1 to bit 31 flushes the log, clears the overflow flag and zeroes the drop counter.
- 0x03 LOG_STATUS (RO): {overflow sticky bit31, 22'b0, occupancy [8:0]}.
- 0x04 LOG_POP (RO, destructive):
  - Returns {valid bit31, 4'b0, ch[2:0] at bits 26:24, 8'b0, id zero-extended at [15:0]}.
  - Pops the head entry when the log is non-empty.
  - An empty log returns 0 and leaves the pointers unchanged.
- 0x05 DROP_CNT (RO): number of log entries lost, saturating.
- 0x10+2i CNT_i (RO): event count for channel i, saturating at all ones; never wraps.
- 0x11+2i LAST_i (RO): last non-zero ID seen on channel i.
- Unmapped reads return 32'hDEADDEAD.
- Writes to RO or unmapped addresses are ignored.

Event rules, per cycle:
- An event on channel i is accepted only when enable bit i = 1 and freeze = 0.
- An accepted event increments CNT_i (saturating) and sets LAST_i to the ID.
- Log push takes one entry per cycle, from the lowest-index channel with an accepted event.
- Each additional accepted event in that same cycle increments DROP_CNT.
- If the log is full and no pop occurs in that cycle, the push is discarded, DROP_CNT increments and overflow is set.
- A pop and a push in the same cycle on a full log both take effect; no drop occurs.

Precedence and freeze:
- Clear vs event on the same channel in the same cycle: clear wins; the counter and last-ID end at 0.
- Flush vs push in the same cycle: flush wins; the log ends empty.
- Freeze stops all counter, last-ID and log updates.
- LOG_POP, CLEAR and register reads remain functional while frozen.

Reset (`rst` = 0, asynchronous):
- All counters, last-IDs, DROP_CNT, overflow, log pointers and occupancy go to 0.
- CTRL goes to enables all ones, freeze 0.
- `udp_reg_ack` goes to 0 and `udp_reg_rd_data` goes to 0.
- Reset in the middle of a request aborts it; no ack is produced.

## Timing
- A request sampled at rising edge t produces `udp_reg_ack` = 1 for exactly one cycle after edge t, with `udp_reg_rd_data` valid in that same cycle.
- Outside ack cycles `udp_reg_rd_data` = 0. Writes produce an ack with read data 0.
- Back-to-back requests on consecutive cycles are each acknowledged on consecutive cycles.
- Write effect: a register write sampled at edge t takes effect at edge t, so an event in the cycle after the write already sees the new CTRL value.
- Event latency:
  - An event present at edge t is reflected in the registers after edge t.
  - A read sampled at edge t returns the value before that edge's event; the same-cycle event is not included.
- A pop sampled at edge t returns the head entry as it was before edge t. A push at the same edge lands behind it.
- Occupancy counts 0..LOG_DEPTH and needs log2(LOG_DEPTH)+1 bits. Pointers wrap modulo LOG_DEPTH.

## Test plan
- **Reset defaults:** release reset, then read 0x00, 0x01 and 0x10 → 0xAAAA0410, 0x0000000F and 0 (defaults NUM_CH=4, LOG_DEPTH=16).
- **Counting and last-ID:** drive ch1 IDs 5, 0, 9 on three cycles → CNT_1 = 2, LAST_1 = 9. Drive 0x3FFF on ch0 with CNT_W=8 for 300 cycles → CNT_0 = 0xFF.
- **Simultaneous events:** drive ch0=3 and ch2=7 in the same cycle → both counters read 1, LOG_STATUS occupancy = 1, DROP_CNT = 1, LOG_POP = 0x80000003. A second pop → 0.
- **Log overflow:** push 17 single events with no pops → occupancy 16 and overflow = 1. Then a pop and a push in the same cycle → occupancy stays 16 and DROP_CNT stays 1.
- **Clear, enable and freeze:** clear ch0 in the same cycle as a ch0 event → CNT_0 = 0. Set CTRL = 0x8000000F and drive events → no change. Set CTRL = 0x0000000E and drive a ch0 event → CNT_0 stays 0.
- **Reset mid-transaction:** assert `rst` the cycle after a read request → no ack, all registers at reset values. A subsequent read of 0x7F → 0xDEADDEAD.
